// File: rtl/alu_uart_iface_if.sv
// Bus bundle between the ALU/UART frame controller and its surroundings:
// the UART receive/transmit FIFO handshakes plus the registered ALU operand/result path.
interface alu_uart_iface_if #(
  parameter int N_BIT = 8,
  parameter int N_OP  = 6
);
  logic             rx_empty;
  logic [N_BIT-1:0] r_data;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [N_BIT-1:0] w_data;
  logic [N_BIT-1:0] alu_a;
  logic [N_BIT-1:0] alu_b;
  logic [N_OP-1:0]  alu_op;
  logic [N_BIT-1:0] alu_res;

  // The controller drives the FIFO strobes and the ALU operands.
  modport master (
    input  rx_empty, r_data, tx_full, alu_res,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_res,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_uart_iface.sv
// Collects A, B and opcode bytes from a UART RX FIFO, lets an external ALU compute, and pushes the result to the TX FIFO.
// Optional frame timeout is compiled in with the macro ALU_IF_TIMEOUT_EN.
module alu_uart_iface #(
  parameter int N_BIT  = 8,
  parameter int N_OP   = 6,
  parameter int TO_W   = 26,
  parameter int TO_MAX = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  alu_uart_iface_if.master    bus,
  output logic                to_err
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, CALC, SEND} state_t;

  state_t state;
  state_t state_next;
  logic   load_a;
  logic   load_b;
  logic   load_op;
  logic   load_res;
  logic   timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GET_A;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
      bus.w_data <= '0;
    end else begin
      state <= state_next;
      if (load_a)   bus.alu_a  <= bus.r_data;
      if (load_b)   bus.alu_b  <= bus.r_data;
      if (load_op)  bus.alu_op <= bus.r_data[N_OP-1:0];
      if (load_res) bus.w_data <= bus.alu_res;
    end
  end

`ifdef ALU_IF_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = ((state == GET_B) || (state == GET_OP)) && bus.rx_empty;
  assign timeout = !reset && waiting && (to_cnt == TO_LAST);

  // Sitting in GET_A keeps the counter cleared, which covers every entry into GET_A.
  always_ff @(posedge clk) begin
    if (reset || timeout || bus.rd_uart || (state == GET_A)) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign to_err = timeout;

  // Strobes are gated by reset so nothing is popped or pushed while reset is held.
  always_comb begin
    state_next  = state;
    bus.rd_uart = 1'b0;
    bus.wr_uart = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    load_res    = 1'b0;
    if (!reset) begin
      case (state)
        GET_A: begin
          if (!bus.rx_empty) begin
            bus.rd_uart = 1'b1;
            load_a      = 1'b1;
            state_next  = GET_B;
          end
        end
        GET_B: begin
          if (timeout) begin
            state_next = GET_A;
          end else if (!bus.rx_empty) begin
            bus.rd_uart = 1'b1;
            load_b      = 1'b1;
            state_next  = GET_OP;
          end
        end
        GET_OP: begin
          if (timeout) begin
            state_next = GET_A;
          end else if (!bus.rx_empty) begin
            bus.rd_uart = 1'b1;
            load_op     = 1'b1;
            state_next  = CALC;
          end
        end
        CALC: begin
          load_res   = 1'b1;
          state_next = SEND;
        end
        SEND: begin
          if (!bus.tx_full) begin
            bus.wr_uart = 1'b1;
            state_next  = GET_A;
          end
        end
        default: state_next = GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_iface.sv
// Self-checking bench for alu_uart_iface: queue-based RX FIFO model, strobe monitor and frame-level reference model.
// Build with ALU_IF_TIMEOUT_EN defined to exercise the frame timeout.
module tb_alu_uart_iface;
  localparam int N_BIT  = 8;
  localparam int N_OP   = 6;
  localparam int TO_W   = 26;
  localparam int TO_MAX = 100;

  logic clk = 1'b0;
  logic reset;
  logic to_err;

  alu_uart_iface_if #(.N_BIT(N_BIT), .N_OP(N_OP)) bus ();

  alu_uart_iface #(.N_BIT(N_BIT), .N_OP(N_OP), .TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .to_err (to_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int to_cnt = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  int last_to_cyc = 0;
  int bad_strobe = 0;
  bit rd_seen = 1'b0;
  bit prev_wr = 1'b0;
  logic [N_BIT-1:0] rx_q[$];
  logic [N_BIT-1:0] tx_log[$];

  // Reference ALU: ADD, SUB, AND, OR, XOR, NOR; any other opcode passes A through.
  function automatic logic [N_BIT-1:0] alu_ref(input logic [N_BIT-1:0] a, input logic [N_BIT-1:0] b,
                                               input logic [N_OP-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  always_comb bus.alu_res = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  // RX FIFO model: pops the head one posedge after a sampled rd_uart.
  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rd_seen && rx_q.size() > 0) void'(rx_q.pop_front());
      bus.rx_empty = (rx_q.size() == 0);
      bus.r_data   = (rx_q.size() > 0) ? rx_q[0] : '0;
    end
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    rd_seen = bus.rd_uart;
    if (bus.rd_uart) begin
      rd_cnt = rd_cnt + 1;
      last_rd_cyc = cyc;
    end
    if (bus.wr_uart) begin
      wr_cnt = wr_cnt + 1;
      last_wr_cyc = cyc;
      tx_log.push_back(bus.w_data);
    end
    if (to_err) begin
      to_cnt = to_cnt + 1;
      last_to_cyc = cyc;
    end
    if ((bus.rd_uart && bus.wr_uart) || (reset && (bus.rd_uart || bus.wr_uart || to_err)) ||
        (bus.wr_uart && prev_wr) || (bus.rd_uart && bus.rx_empty))
      bad_strobe = bad_strobe + 1;
    prev_wr = bus.wr_uart;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_cnt >= target) break;
      tick();
    end
    ok = (wr_cnt >= target);
  endtask

  task automatic wait_reads(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rd_cnt >= target) break;
      tick();
    end
    ok = (rd_cnt >= target);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_q.push_back(8'hAA);
    repeat (3) tick();
    checks++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_operands: got a=%h b=%h required 00 00", bus.alu_a, bus.alu_b);
    end
    checks++;
    if (bus.alu_op !== 6'h00 || bus.w_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_op_wdata: got op=%h w_data=%h required 00 00", bus.alu_op, bus.w_data);
    end
    checks++;
    if (rd_cnt !== 0 || bus.rd_uart !== 1'b0 || to_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got rd_cnt=%0d rd_uart=%b to_err=%b required 0 0 0",
               rd_cnt, bus.rd_uart, to_err);
    end
    rx_q.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    bit ok;
    push3(8'h05, 8'h03, 8'h20);
    wait_writes(w0 + 1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_wait: got %0d writes required %0d", wr_cnt - w0, 1);
    end else begin
      checks++;
      if (tx_log[w0] !== 8'h08) begin
        errors++;
        $display("[TB] FAIL single_w_data: got %h required 08", tx_log[w0]);
      end
      checks++;
      if (last_wr_cyc - last_rd_cyc !== 2) begin
        errors++;
        $display("[TB] FAIL single_latency: got %0d required 2", last_wr_cyc - last_rd_cyc);
      end
      checks++;
      if (bus.alu_a !== 8'h05 || bus.alu_b !== 8'h03 || bus.alu_op !== 6'h20) begin
        errors++;
        $display("[TB] FAIL single_operands: got %h %h %h required 05 03 20", bus.alu_a, bus.alu_b, bus.alu_op);
      end
      checks++;
      if (rd_cnt - r0 !== 3) begin
        errors++;
        $display("[TB] FAIL single_reads: got %0d required 3", rd_cnt - r0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    bit ok;
    push3(8'hFF, 8'h01, 8'h20);
    push3(8'h10, 8'h04, 8'h22);
    wait_writes(w0 + 2, 60, ok);
    repeat (6) tick();
    checks++;
    if (!ok || rd_cnt - r0 !== 6 || wr_cnt - w0 !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got rd=%0d wr=%0d required 6 2", rd_cnt - r0, wr_cnt - w0);
    end else begin
      checks++;
      if (tx_log[w0] !== 8'h00 || tx_log[w0+1] !== 8'h0C) begin
        errors++;
        $display("[TB] FAIL b2b_data: got %h %h required 00 0c", tx_log[w0], tx_log[w0+1]);
      end
    end
  endtask

  task automatic test_tx_full();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    int drop_cyc;
    int bad = 0;
    bit ok;
    bus.tx_full = 1'b1;
    push3(8'h30, 8'h12, 8'h24);
    wait_reads(r0 + 3, 40, ok);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (wr_cnt != w0 || bus.w_data !== 8'h10 || bus.wr_uart !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("[TB] FAIL txfull_hold: got %0d bad cycles (reads ok=%b) required 0", bad, ok);
    end
    drop_cyc = cyc + 1;
    bus.tx_full = 1'b0;
    tick();
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_cyc !== drop_cyc) begin
      errors++;
      $display("[TB] FAIL txfull_release: got writes=%0d at cyc %0d required 1 at cyc %0d",
               wr_cnt - w0, last_wr_cyc, drop_cyc);
    end
    repeat (4) tick();
    checks++;
    if (wr_cnt - w0 !== 1 || tx_log[tx_log.size()-1] !== 8'h10) begin
      errors++;
      $display("[TB] FAIL txfull_single: got writes=%0d last=%h required 1 10", wr_cnt - w0, tx_log[tx_log.size()-1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    bit ok;
    rx_q.push_back(8'h7E);
    wait_reads(r0 + 1, 20, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (!ok || bus.alu_a !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_a: got alu_a=%h (read ok=%b) required 00", bus.alu_a, ok);
    end
    repeat (5) tick();
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("[TB] FAIL midreset_nowrite: got %0d writes required 0", wr_cnt - w0);
    end
    push3(8'h01, 8'h01, 8'h20);
    wait_writes(w0 + 1, 40, ok);
    checks++;
    if (!ok || tx_log[tx_log.size()-1] !== 8'h02) begin
      errors++;
      $display("[TB] FAIL midreset_next: got writes=%0d required result 02", wr_cnt - w0);
    end
  endtask

  task automatic test_timeout();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    int t0 = to_cnt;
    int rd_c;
    bit ok;
    rx_q.push_back(8'h11);
    wait_reads(r0 + 1, 20, ok);
    rd_c = last_rd_cyc;
`ifdef ALU_IF_TIMEOUT_EN
    for (int i = 0; i < 150; i++) begin
      if (to_cnt > t0) break;
      tick();
    end
    repeat (5) tick();
    checks++;
    if (!ok || to_cnt - t0 !== 1 || last_to_cyc - rd_c !== 100) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got pulses=%0d delay=%0d required 1 100", to_cnt - t0, last_to_cyc - rd_c);
    end
    checks++;
    if (bus.alu_a !== 8'h11 || wr_cnt !== w0) begin
      errors++;
      $display("[TB] FAIL timeout_retain: got alu_a=%h writes=%0d required 11 0", bus.alu_a, wr_cnt - w0);
    end
    push3(8'h02, 8'h03, 8'h20);
    wait_writes(w0 + 1, 40, ok);
    checks++;
    if (!ok || tx_log[tx_log.size()-1] !== 8'h05) begin
      errors++;
      $display("[TB] FAIL timeout_next: got writes=%0d required result 05", wr_cnt - w0);
    end
`else
    repeat (150) tick();
    checks++;
    if (!ok || to_cnt !== t0 || wr_cnt !== w0) begin
      errors++;
      $display("[TB] FAIL notimeout_idle: got pulses=%0d writes=%0d required 0 0", to_cnt - t0, wr_cnt - w0);
    end
    push3(8'h02, 8'h03, 8'h20);
    wait_writes(w0 + 1, 40, ok);
    checks++;
    if (!ok || tx_log[tx_log.size()-1] !== alu_ref(8'h11, 8'h02, 6'h03) || bus.alu_a !== 8'h11) begin
      errors++;
      $display("[TB] FAIL notimeout_frame: got writes=%0d alu_a=%h required 1 11", wr_cnt - w0, bus.alu_a);
    end
    rx_q.push_back(8'h04);
    rx_q.push_back(8'h20);
    wait_writes(w0 + 2, 40, ok);
    checks++;
    if (!ok || tx_log[tx_log.size()-1] !== 8'h24) begin
      errors++;
      $display("[TB] FAIL notimeout_tail: got writes=%0d required result 24", wr_cnt - w0);
    end
`endif
  endtask

  task automatic test_random_frames();
    logic [N_OP-1:0] ops[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00};
    logic [7:0] stream[$];
    logic [7:0] expected[$];
    logic [7:0] a, b, op;
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    int pushed = 0;
    for (int f = 0; f < 20; f++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = {2'($urandom), ops[$urandom_range(0, 6)]};
      stream.push_back(a);
      stream.push_back(b);
      stream.push_back(op);
      expected.push_back(alu_ref(a, b, op[N_OP-1:0]));
    end
    for (int i = 0; i < 3000; i++) begin
      if (wr_cnt >= w0 + 20) break;
      if (pushed < stream.size() && $urandom_range(0, 2) != 0) begin
        rx_q.push_back(stream[pushed]);
        pushed++;
      end
      bus.tx_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.tx_full = 1'b0;
    repeat (5) tick();
    checks++;
    if (wr_cnt - w0 !== 20 || rd_cnt - r0 !== 60) begin
      errors++;
      $display("[TB] FAIL random_counts: got wr=%0d rd=%0d required 20 60", wr_cnt - w0, rd_cnt - r0);
    end else begin
      for (int f = 0; f < 20; f++) begin
        checks++;
        if (tx_log[w0+f] !== expected[f]) begin
          errors++;
          $display("[TB] FAIL random_frame%0d: got %h required %h", f, tx_log[w0+f], expected[f]);
        end
      end
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (bad_strobe !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_rules: got %0d bad cycles required 0", bad_strobe);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.tx_full = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_tx_full();
    test_reset_mid_frame();
    test_timeout();
    test_random_frames();
    test_strobe_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
